// File: rtl/led_pkg.sv
// led_pkg: shared LED matrix sizes, row/frame types, buffer FSM states and row rotation
package led_pkg;
  localparam int LED_ROWS = 4;
  localparam int LED_COLS = 8;
  typedef logic [LED_COLS-1:0] led_row_t;
  typedef led_row_t [LED_ROWS-1:0] led_frame_t;
  typedef enum logic {IDLE, PENDING} fb_state_t;
  function automatic led_row_t rot(led_row_t r, logic dir);
    return dir ? {r[0], r[LED_COLS-1:1]} : {r[LED_COLS-2:0], r[LED_COLS-1]};
  endfunction
endpackage

// File: rtl/led_frame_timer.sv
// led_frame_timer: free-running scan frame counter with a pulse on the last cycle of each frame
module led_frame_timer #(
  parameter int FRAME_CYCLES = 4096
) (
  input  logic clk12MHz,
  input  logic reset,
  output logic frame_tick
);
  localparam int CW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
  logic [CW-1:0] cnt;
  assign frame_tick = cnt == CW'(FRAME_CYCLES - 1);
  always_ff @(posedge clk12MHz)
    if (reset) cnt <= '0;
    else cnt <= frame_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered 4x8 frame store with tear-free commit and row scrolling
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int FRAME_CYCLES  = 4096,
  parameter int SCROLL_FRAMES = 293
) (
  input  logic           clk12MHz,
  input  logic           reset,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [1:0]     wr_row,
  input  led_row_t       wr_data,
  input  logic           commit,
  output logic           pending,
  input  logic           scroll_en,
  input  logic           scroll_dir,
  output logic           frame_tick,
  output led_row_t       leds1,
  output led_row_t       leds2,
  output led_row_t       leds3,
  output led_row_t       leds4
);
  localparam int SW = SCROLL_FRAMES > 1 ? $clog2(SCROLL_FRAMES) : 1;
  fb_state_t state;
  led_frame_t s, a;
  logic [SW-1:0] scnt;
  led_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .clk12MHz  (clk12MHz),
    .reset     (reset),
    .frame_tick(frame_tick)
  );
  assign pending  = state == PENDING;
  assign wr_ready = !reset && state == IDLE;
  assign leds1 = a[0];
  assign leds2 = a[1];
  assign leds3 = a[2];
  assign leds4 = a[3];
  // a swap on a boundary wins over a scroll step on that same boundary
  always_ff @(posedge clk12MHz)
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      a     <= '0;
      scnt  <= '0;
    end else begin
      if (state == IDLE) begin
        if (wr_valid) s[wr_row] <= wr_data;
        if (commit) state <= PENDING;
      end else if (frame_tick) begin
        a     <= s;
        state <= IDLE;
      end
      if ((state == PENDING && frame_tick) || !scroll_en) scnt <= '0;
      else if (frame_tick) begin
        if (scnt == SW'(SCROLL_FRAMES - 1)) begin
          scnt <= '0;
          for (int k = 0; k < LED_ROWS; k++) a[k] <= rot(a[k], scroll_dir);
        end else scnt <= scnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_led_frame_buffer.sv
// tb_led_frame_buffer: directed checks of commit timing, write blocking, scrolling and reset
module tb_led_frame_buffer;
  localparam int FC = 1024;
  logic clk12MHz = 1'b0;
  logic reset, wr_valid, wr_ready, commit, pending, scroll_en, scroll_dir, frame_tick;
  logic [1:0] wr_row;
  logic [7:0] wr_data, leds1, leds2, leds3, leds4;
  int total = 0, bad = 0;
  led_frame_buffer #(.FRAME_CYCLES(FC), .SCROLL_FRAMES(2)) dut (
    .clk12MHz(clk12MHz), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .pending(pending),
    .scroll_en(scroll_en), .scroll_dir(scroll_dir), .frame_tick(frame_tick),
    .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4)
  );
  always #5 clk12MHz = ~clk12MHz;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk12MHz);
    #1;
  endtask
  task automatic wait_tick();
    int n = 0;
    while (!frame_tick && n < FC + 2) begin
      step();
      n++;
    end
    if (!frame_tick) chk("tick_timeout", 0, 1);
  endtask
  task automatic wr(input logic [1:0] row, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_row   = row;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask
  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask
  task automatic chk_rows(input string tag, input logic [31:0] exp);
    chk(tag, {leds4, leds3, leds2, leds1}, exp);
  endtask
  initial begin
    int n;
    reset = 1'b1; wr_valid = 1'b0; wr_row = '0; wr_data = '0;
    commit = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0;
    repeat (3) step();
    chk_rows("reset_leds", 32'h0);
    chk("reset_ready", wr_ready, 0);
    chk("reset_pending", pending, 0);
    chk("reset_tick", frame_tick, 0);
    reset = 1'b0;
    #1;
    chk("idle_ready", wr_ready, 1);
    n = 0;
    while (!frame_tick && n < FC + 5) begin
      step();
      n++;
    end
    chk("first_tick_cycle", n, FC - 1);
    step();
    wr(0, 8'h81); wr(1, 8'h42); wr(2, 8'h24); wr(3, 8'h18);
    chk_rows("write_no_effect", 32'h0);
    pulse_commit();
    chk("commit_pending", pending, 1);
    chk("commit_ready", wr_ready, 0);
    wait_tick();
    chk_rows("pre_boundary", 32'h0);
    step();
    chk_rows("post_boundary", 32'h18244281);
    chk("post_pending", pending, 0);
    wr(0, 8'h5A);
    wait_tick();
    pulse_commit();
    chk("bcommit_pending", pending, 1);
    chk_rows("bcommit_held", 32'h18244281);
    n = 0;
    while (leds1 != 8'h5A && n < FC + 5) begin
      step();
      n++;
    end
    chk("bcommit_delay", n, FC);
    chk_rows("bcommit_rows", 32'h1824425A);
    pulse_commit();
    wr_valid = 1'b1; wr_row = 2'd2; wr_data = 8'hFF;
    step();
    chk("blocked_ready", wr_ready, 0);
    step();
    wr_valid = 1'b0;
    wait_tick();
    step();
    chk("blocked_leds3", leds3, 8'h24);
    for (int r = 0; r < 4; r++) wr(r[1:0], 8'h81);
    pulse_commit();
    wait_tick();
    step();
    chk_rows("scroll_load", 32'h81818181);
    scroll_en = 1'b1;
    wait_tick();
    step();
    chk_rows("scroll_b1", 32'h81818181);
    wait_tick();
    step();
    chk_rows("scroll_b2", 32'h03030303);
    for (int b = 3; b <= 16; b++) begin
      wait_tick();
      step();
    end
    chk_rows("scroll_b16", 32'h81818181);
    scroll_dir = 1'b1;
    repeat (2) begin
      wait_tick();
      step();
    end
    chk_rows("scroll_right", 32'hC0C0C0C0);
    scroll_en = 1'b0;
    for (int r = 0; r < 4; r++) wr(r[1:0], 8'hAA);
    pulse_commit();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_rows("midreset_leds", 32'h0);
    chk("midreset_pending", pending, 0);
    wait_tick();
    step();
    chk_rows("midreset_after", 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_frame_buffer.md
# led_frame_buffer

Double-buffered 4×8 frame store that sits directly upstream of the LED matrix scan driver and feeds its four row-byte inputs. Producers write rows into a shadow buffer through a valid/ready port, then request a commit. The shadow is copied to the displayed buffer only on a scan-frame boundary, so the display never tears. An optional scroll engine rotates the displayed rows at a fixed frame rate.

## Interface
- `FRAME_CYCLES`, 4096: clock cycles per scan frame; matches the scan driver's 12-bit counter period.
- `SCROLL_FRAMES`, 293: frames between scroll steps (≈10 Hz at 12 MHz); must be ≥1.
- `clk12MHz` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1: row-write request.
- `wr_ready` out 1: the buffer accepts a write this cycle.
- `wr_row` in 2: shadow row index, 0..3.
- `wr_data` in 8: row data; bit n = LED n, 1 = lit.
- `commit` in 1: request that the shadow be shown at the next frame boundary.
- `pending` out 1: a commit is waiting for the frame boundary.
- `scroll_en` in 1: enables rotation of the displayed rows.
- `scroll_dir` in 1: 0 = rotate left (bit7←bit6…bit0←bit7); 1 = rotate right.
- `frame_tick` out 1: one-cycle pulse on the last cycle of each frame.
- `leds1`..`leds4` out 8 each: displayed rows 0..3, fed to the scan driver's row inputs.

## Operation
- Storage:
  - Shadow `S[0..3]` and active `A[0..3]`, 8 bits each.
  - `leds(k+1) = A[k]`, driven straight from registers with no output logic.
- Frame timer:
  - Counter runs 0..FRAME_CYCLES-1, then wraps.
  - Boundary = counter at FRAME_CYCLES-1; `frame_tick` is high on that cycle.
- Control FSM, two states:
  - IDLE (`pending`=0): `wr_ready`=1. A handshake (`wr_valid`&`wr_ready`) writes `S[wr_row]<=wr_data`. `commit` → PENDING.
  - PENDING (`pending`=1): `wr_ready`=0 and writes are ignored. `commit` is ignored. On the boundary: `A<=S`, scroll counter ←0, → IDLE.
- Scroll engine:
  - Scroll counter counts boundaries, 0..SCROLL_FRAMES-1.
  - On a boundary with no swap, `scroll_en`=1 and counter = SCROLL_FRAMES-1: all four `A` rows rotate by one bit in `scroll_dir`, and the counter returns to 0.
  - `scroll_en`=0 holds the counter at 0.
  - A swap on a boundary takes priority over a scroll step on that boundary; no scroll step occurs then.
- Rotation changes only `A`; `S` is never modified by scrolling.

## Timing
- Reset values:
  - All of `A`, `S`, both counters, `pending`, `frame_tick`, `leds1..4` = 0.
  - `wr_ready`=0 while `reset` is high and 1 on the first cycle after it.
- Write latency: 1 cycle to `S`. Writes never affect the outputs until a commit.
- Commit latency:
  - `pending` rises on the cycle after `commit`.
  - The outputs change on the cycle after the first boundary cycle that is strictly later than the `commit` cycle.
  - Worst case is FRAME_CYCLES+1 cycles.
- `commit` on a boundary cycle: no swap on that boundary; the swap happens one frame later.
- Write and `commit` in the same IDLE cycle: the write lands in `S`, and that data is included in the swap.
- Writes to the same row in consecutive cycles: the last one wins.
- Scroll step: the outputs change on the cycle after the boundary.
- Reset mid-PENDING: the commit is discarded and the outputs return to 0.
- `wr_row` is always in range (2 bits); there is no error path.

## Structure
- Package `led_pkg`:
  - `LED_ROWS`=4, `LED_COLS`=8.
  - `led_row_t` (8-bit) and `led_frame_t` (4×`led_row_t`).
  - FSM state enum `fb_state_t` {IDLE, PENDING}.
- Sub-module `led_frame_timer` (parameter `FRAME_CYCLES`):
  - Provides the frame counter and `frame_tick`.
  - Reused by other display producers that must stay frame-aligned.
- The top level holds the buffers, the FSM and the scroll counter.

## Test plan
- **Reset and idle:** hold `reset` 3 cycles, release → `leds1..4`=0x00, `wr_ready`=1, `pending`=0, `frame_tick` first high at cycle 4095 after release.
- **Write and commit:**
  - Stimulus: write rows 0..3 = 0x81, 0x42, 0x24, 0x18, then pulse `commit` mid-frame.
  - Before the boundary: outputs stay 0x00, `pending`=1, `wr_ready`=0.
  - After the boundary: `leds1..4` = 0x81, 0x42, 0x24, 0x18, `pending`=0.
- **Commit on a boundary cycle:** outputs are unchanged after that boundary and update exactly one frame (4096 cycles) later.
- **Write blocked while pending:**
  - Stimulus: write row 2 = 0xFF while `pending`=1, with no handshake.
  - After the next commit: `leds3` shows the earlier value 0x24.
- **Scroll:**
  - Use `SCROLL_FRAMES`=2 for this scenario.
  - Stimulus: display 0x81 on all rows, `scroll_en`=1, `scroll_dir`=0.
  - After 2 boundaries: all rows = 0x03. After 16 boundaries: 0x81 again. With `scroll_dir`=1, 0x81 → 0xC0.
- **Reset mid-pending:** commit 0xAA data, assert `reset` before the boundary → outputs 0x00, `pending`=0, and no 0xAA appears after the boundary.
